mem_flash_txn_sequencer: RTL and testbench

//  Sequences complete flash transactions onto the byte-level SPI engine (mem_spi_controller).

---
 rtl/mem_flash_txn_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_flash_txn_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_flash_txn_sequencer.sv
// mem_flash_txn_sequencer
// Turns one read or page-program request into the byte-by-byte transfer sequence
// for the SPI engine. The sequence is WREN (writes only), opcode, three address
// bytes, dummy bytes (quad reads only) and then the data bytes. Read and write
// data are streamed to and from the requester with valid/ready handshakes.
module mem_flash_txn_sequencer #(
  parameter logic [7:0]  RD_OP       = 8'h03,
  parameter logic [7:0]  QRD_OP      = 8'h6B,
  parameter logic [7:0]  WR_OP       = 8'h02,
  parameter logic [7:0]  WREN_OP     = 8'h06,
  parameter int unsigned DUMMY_BYTES = 1,
  parameter int unsigned LEN_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rw,
  input  logic             req_quad,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  input  logic             rd_ready,
  output logic             txn_done,
  output logic             spi_start,
  output logic             spi_r_w,
  output logic             spi_quad,
  output logic [7:0]       spi_tx_data,
  input  logic             spi_busy,
  input  logic             spi_done,
  input  logic             spi_rx_valid,
  input  logic [7:0]       spi_rx_data,
  output logic             spi_rx_ready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_WREN = 3'd1, S_CMD = 3'd2, S_ADDR = 3'd3,
    S_DUMMY = 3'd4, S_DATA = 3'd5, S_FIN = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    P_ISSUE = 2'd0, P_WAIT = 2'd1, P_RDHOLD = 2'd2
  } phase_t;

  localparam logic [1:0]       DUMMY_N = 2'(DUMMY_BYTES);
  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  state_t           r_state;
  phase_t           r_phase;
  logic [1:0]       r_idx;
  logic             r_rw;
  logic             r_quad;
  logic [23:0]      r_addr;
  logic [LEN_W-1:0] r_cnt;
  logic             r_req_ready;
  logic             r_wr_ready;
  logic             r_rd_valid;
  logic [7:0]       r_rd_data;
  logic             r_txn_done;
  logic             r_spi_start;
  logic             r_spi_r_w;
  logic             r_spi_quad;
  logic [7:0]       r_spi_tx_data;
  logic             r_spi_rx_ready;

  state_t     w_next_state;
  state_t     w_data_next;
  logic [7:0] w_opcode;
  logic [7:0] w_tx_byte;
  logic       w_in_data;
  logic       w_issue_ok;
  logic       w_adv;

  assign req_ready    = r_req_ready;
  assign wr_ready     = r_wr_ready;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_data;
  assign txn_done     = r_txn_done;
  assign spi_start    = r_spi_start;
  assign spi_r_w      = r_spi_r_w;
  assign spi_quad     = r_spi_quad;
  assign spi_tx_data  = r_spi_tx_data;
  assign spi_rx_ready = r_spi_rx_ready;

  // Byte to send in the current phase, the phase that follows it, and when to advance.
  always_comb begin
    w_in_data    = (r_state == S_DATA);
    w_opcode     = r_rw ? (r_quad ? QRD_OP : RD_OP) : WR_OP;
    w_data_next  = (r_cnt != '0) ? S_DATA : S_FIN;
    w_tx_byte    = 8'h00;
    w_next_state = S_IDLE;
    case (r_state)
      S_WREN: begin
        w_tx_byte    = WREN_OP;
        w_next_state = S_CMD;
      end
      S_CMD: begin
        w_tx_byte    = w_opcode;
        w_next_state = S_ADDR;
      end
      S_ADDR: begin
        case (r_idx)
          2'd0:    w_tx_byte = r_addr[23:16];
          2'd1:    w_tx_byte = r_addr[15:8];
          default: w_tx_byte = r_addr[7:0];
        endcase
        if (r_idx != 2'd2) begin
          w_next_state = S_ADDR;
        end else if (r_rw && r_quad && (DUMMY_N != 2'd0)) begin
          w_next_state = S_DUMMY;
        end else begin
          w_next_state = w_data_next;
        end
      end
      S_DUMMY: begin
        w_tx_byte = 8'h00;
        if (r_idx != (DUMMY_N - 2'd1)) begin
          w_next_state = S_DUMMY;
        end else begin
          w_next_state = w_data_next;
        end
      end
      S_DATA: begin
        w_tx_byte = r_rw ? 8'h00 : wr_data;
        if (r_cnt > CNT_ONE) begin
          w_next_state = S_DATA;
        end else begin
          w_next_state = S_FIN;
        end
      end
      default: begin
        w_tx_byte    = 8'h00;
        w_next_state = S_IDLE;
      end
    endcase
    // A write data byte may only start once the requester has one ready.
    w_issue_ok = !spi_busy && !spi_done && (!w_in_data || r_rw || wr_valid);
    // A byte is finished once the engine is done, and for read data once the requester took it.
    w_adv = ((r_phase == P_WAIT) && spi_done && !(w_in_data && r_rw)) ||
            ((r_phase == P_RDHOLD) && rd_ready);
  end

  // Transaction FSM with its byte sub-phase; every output is driven from a register here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_phase        <= P_ISSUE;
      r_idx          <= 2'd0;
      r_rw           <= 1'b0;
      r_quad         <= 1'b0;
      r_addr         <= 24'h000000;
      r_cnt          <= '0;
      r_req_ready    <= 1'b1;
      r_wr_ready     <= 1'b0;
      r_rd_valid     <= 1'b0;
      r_rd_data      <= 8'h00;
      r_txn_done     <= 1'b0;
      r_spi_start    <= 1'b0;
      r_spi_r_w      <= 1'b0;
      r_spi_quad     <= 1'b0;
      r_spi_tx_data  <= 8'h00;
      r_spi_rx_ready <= 1'b0;
    end else begin
      r_spi_start    <= 1'b0;
      r_wr_ready     <= 1'b0;
      r_txn_done     <= 1'b0;
      r_spi_rx_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_rw        <= req_rw;
            r_quad      <= req_quad;
            r_addr      <= req_addr;
            r_cnt       <= req_len;
            r_req_ready <= 1'b0;
            r_idx       <= 2'd0;
            r_phase     <= P_ISSUE;
            r_state     <= req_rw ? S_CMD : S_WREN;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_FIN: begin
          r_txn_done <= 1'b1;
          r_phase    <= P_ISSUE;
          r_state    <= S_IDLE;
        end
        default: begin
          case (r_phase)
            P_ISSUE: begin
              if (w_issue_ok) begin
                r_spi_start   <= 1'b1;
                r_spi_tx_data <= w_tx_byte;
                r_spi_r_w     <= w_in_data && r_rw;
                r_spi_quad    <= w_in_data && r_quad;
                r_wr_ready    <= w_in_data && !r_rw;
                r_phase       <= P_WAIT;
              end else begin
                r_phase <= P_ISSUE;
              end
            end
            P_WAIT: begin
              if (spi_done && w_in_data && r_rw) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= spi_rx_data;
                r_phase    <= P_RDHOLD;
              end else begin
                r_phase <= P_WAIT;
              end
            end
            P_RDHOLD: begin
              if (rd_ready) begin
                r_rd_valid     <= 1'b0;
                r_spi_rx_ready <= 1'b1;
              end else begin
                r_rd_valid <= 1'b1;
              end
            end
            default: r_phase <= P_ISSUE;
          endcase
          if (w_adv) begin
            r_state <= w_next_state;
            r_phase <= P_ISSUE;
            r_idx   <= (w_next_state == r_state) ? (r_idx + 2'd1) : 2'd0;
            if (w_in_data && (r_cnt != '0)) begin
              r_cnt <= r_cnt - CNT_ONE;
            end else begin
              r_cnt <= r_cnt;
            end
          end else begin
            r_state <= r_state;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_flash_txn_sequencer.sv
// Bench for mem_flash_txn_sequencer: a behavioural engine and requester plus a
// transaction-level model of the byte sequence each request must produce.
module tb_mem_flash_txn_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, req_ready, req_rw, req_quad;
  logic [23:0] req_addr;
  logic [7:0]  req_len;
  logic        wr_valid, wr_ready, rd_valid, rd_ready, txn_done;
  logic [7:0]  wr_data, rd_data;
  logic        spi_start, spi_r_w, spi_quad, spi_busy, spi_done, spi_rx_valid, spi_rx_ready;
  logic [7:0]  spi_tx_data, spi_rx_data;

  mem_flash_txn_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_quad(req_quad),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .txn_done(txn_done),
    .spi_start(spi_start), .spi_r_w(spi_r_w), .spi_quad(spi_quad), .spi_tx_data(spi_tx_data),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_rx_valid(spi_rx_valid),
    .spi_rx_data(spi_rx_data), .spi_rx_ready(spi_rx_ready)
  );

  typedef struct packed {
    logic [7:0] tx;
    logic       rw;
    logic       q;
    logic       chk_tx;
    logic       is_wr;
  } xfer_t;

  xfer_t      exp_q[$];
  logic [7:0] src_rd[$], src_wr[$], exp_rd[$], tx_log[$], rd_log[$];
  logic       q_log[$];
  int         n_chk = 0, n_pass = 0;
  int         done_cnt, wrr_cnt, wr_stall, rd_stall, e_cnt;
  bit         stall_wr_req, exp_rxr;
  logic       e_busy, e_done, e_rw;
  logic [7:0] e_rx, prev_rd_data;
  logic       prev_wr_valid, prev_eng_free, prev_rd_valid, prev_rd_hold;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic xfer_t mk(input logic [7:0] tx, input logic rw, input logic q,
                               input logic c, input logic w);
    xfer_t x;
    x.tx = tx; x.rw = rw; x.q = q; x.chk_tx = c; x.is_wr = w;
    return x;
  endfunction

  task automatic model_clear();
    exp_q.delete(); exp_rd.delete(); src_rd.delete(); src_wr.delete();
    e_busy = 1'b0; e_done = 1'b0; e_rw = 1'b0; e_cnt = 0; e_rx = 8'h00;
    exp_rxr = 1'b0; rd_stall = 0; wr_stall = 0; stall_wr_req = 1'b0;
    prev_wr_valid = 1'b0; prev_eng_free = 1'b1; prev_rd_valid = 1'b0; prev_rd_hold = 1'b0;
    spi_busy = 1'b0; spi_done = 1'b0; spi_rx_valid = 1'b0; spi_rx_data = 8'h00;
    rd_ready = 1'b0; wr_valid = 1'b0;
  endtask

  task automatic chk_reset_outs();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outputs", {wr_ready, rd_valid, rd_data, txn_done, spi_start, spi_r_w,
                        spi_quad, spi_tx_data, spi_rx_ready}, 0);
  endtask

  // One clock: check the outputs at the falling edge, then advance engine and requester models.
  task automatic step();
    xfer_t x;
    logic hand;
    @(negedge clk);
    if (txn_done) done_cnt++;
    chk("spi_rx_ready", spi_rx_ready, exp_rxr);
    if (spi_rx_ready && e_done && e_rw) begin
      e_busy = 1'b0; e_done = 1'b0;
    end
    if (spi_start) begin
      chk("start_engine_free", prev_eng_free, 1);
      chk("start_no_rd_pending", prev_rd_valid, 0);
      tx_log.push_back(spi_tx_data);
      q_log.push_back(spi_quad);
      if (exp_q.size() == 0) begin
        chk("start_unexpected", 1, 0);
      end else begin
        x = exp_q.pop_front();
        if (x.chk_tx) chk("spi_tx_data", spi_tx_data, x.tx);
        chk("spi_r_w", spi_r_w, x.rw);
        chk("spi_quad", spi_quad, x.q);
        chk("wr_ready_with_start", wr_ready, x.is_wr);
        if (x.is_wr) chk("wr_valid_at_issue", prev_wr_valid, 1);
      end
      e_busy = 1'b1; e_done = 1'b0; e_rw = spi_r_w; e_cnt = $urandom_range(1, 4);
    end else begin
      chk("wr_ready_no_start", wr_ready, 0);
      if (e_busy && !e_done) begin
        e_cnt--;
        if (e_cnt == 0) begin
          e_done = 1'b1;
          if (e_rw) e_rx = (src_rd.size() != 0) ? src_rd.pop_front() : 8'hEE;
        end
      end else if (e_done && !e_rw) begin
        e_busy = 1'b0; e_done = 1'b0;
      end
    end
    spi_busy = e_busy; spi_done = e_done;
    spi_rx_valid = e_done && e_rw; spi_rx_data = e_rx;
    prev_eng_free = !e_busy && !e_done;
    // Read side of the requester.
    if (rd_valid) begin
      if (prev_rd_hold) chk("rd_data_stable", rd_data, prev_rd_data);
      if (exp_rd.size() != 0) chk("rd_data", rd_data, exp_rd[0]);
      else chk("rd_unexpected", 1, 0);
    end
    if (rd_stall > 0) begin
      rd_ready = 1'b0;
      if (rd_valid) rd_stall--;
    end else begin
      rd_ready = ($urandom_range(0, 3) != 0);
    end
    hand = rd_valid && rd_ready;
    if (hand) begin
      rd_log.push_back(rd_data);
      if (exp_rd.size() != 0) void'(exp_rd.pop_front());
    end
    exp_rxr = hand;
    prev_rd_hold = rd_valid && !rd_ready;
    prev_rd_data = rd_data;
    prev_rd_valid = rd_valid;
    // Write side of the requester.
    if (wr_ready) begin
      if (src_wr.size() != 0) void'(src_wr.pop_front());
      wrr_cnt++;
      if (stall_wr_req) begin
        wr_stall = 10; stall_wr_req = 1'b0;
      end
    end
    if (wr_stall > 0) begin
      wr_valid = 1'b0; wr_stall--;
    end else begin
      wr_valid = ($urandom_range(0, 3) != 0);
    end
    wr_data = (src_wr.size() != 0) ? src_wr[0] : 8'($urandom);
    prev_wr_valid = wr_valid;
  endtask

  // Build the expected byte sequence for one request, run it, and check its completion.
  task automatic run_txn(input logic rw, input logic q, input logic [23:0] addr,
                         input logic [7:0] len, input int abort_at);
    int t;
    exp_q.delete();
    if (!rw) exp_q.push_back(mk(8'h06, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(rw ? (q ? 8'h6B : 8'h03) : 8'h02, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(addr[23:16], 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(addr[15:8], 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(addr[7:0], 1'b0, 1'b0, 1'b1, 1'b0));
    if (rw && q) exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_rd.delete();
    for (int i = 0; i < int'(len); i++) begin
      if (rw) begin
        exp_q.push_back(mk(8'h00, 1'b1, q, 1'b0, 1'b0));
        exp_rd.push_back(src_rd[i]);
      end else begin
        exp_q.push_back(mk(src_wr[i], 1'b0, q, 1'b1, 1'b1));
      end
    end
    tx_log.delete(); q_log.delete(); rd_log.delete(); done_cnt = 0; wrr_cnt = 0;
    req_valid = 1'b1; req_rw = rw; req_quad = q; req_addr = addr; req_len = len;
    t = 0;
    while (!req_ready && t < 50) begin step(); t++; end
    chk("req_ready_seen", req_ready, 1);
    step();
    chk("req_ready_dropped", req_ready, 0);
    req_valid = 1'b0; req_rw = ~rw; req_quad = ~q; req_addr = 24'($urandom); req_len = 8'($urandom);
    t = 0;
    while (done_cnt == 0 && t < 3000) begin
      step(); t++;
      if (abort_at > 0 && tx_log.size() == abort_at) break;
    end
    if (abort_at == 0) begin
      chk("txn_done_seen", done_cnt, 1);
      chk("exp_bytes_left", exp_q.size(), 0);
      chk("rd_bytes_left", exp_rd.size(), 0);
      chk("wr_ready_count", wrr_cnt, rw ? 0 : int'(len));
      step();
      chk("txn_done_pulse", txn_done, 0);
      chk("req_ready_after_done", req_ready, 1);
      chk("txn_done_total", done_cnt, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rw, q;
    logic [7:0] len;
    rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_quad = 1'b0;
    req_addr = 24'h000000; req_len = 8'h00; wr_data = 8'h00;
    model_clear();
    #12;
    chk_reset_outs();
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("idle_req_ready", req_ready, 1);

    // Single read, engine returns A5, 3C.
    model_clear(); src_rd = '{8'hA5, 8'h3C};
    run_txn(1'b1, 1'b0, 24'h012345, 8'd2, 0);
    chk("rd1_tx_count", tx_log.size(), 6);
    chk("rd1_tx_hdr", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'h03012345);
    chk("rd1_rd_bytes", {rd_log[0], rd_log[1]}, 16'hA53C);

    // Single write of 5A to 0000FF.
    model_clear(); src_wr = '{8'h5A};
    run_txn(1'b0, 1'b0, 24'h0000FF, 8'd1, 0);
    chk("wr1_tx_count", tx_log.size(), 6);
    chk("wr1_tx_all", {tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[4], tx_log[5]},
        48'h06020000FF5A);

    // Quad read, one dummy byte, one data byte.
    model_clear(); src_rd = '{8'hC3};
    run_txn(1'b1, 1'b1, 24'hABCDEF, 8'd1, 0);
    chk("qrd_tx_hdr", {tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[4]}, 40'h6BABCDEF00);
    chk("qrd_quad_flags", {q_log[4], q_log[5]}, 2'b01);
    chk("qrd_rd_byte", rd_log[0], 8'hC3);

    // Write with the requester stalling 10 cycles after the first data byte.
    model_clear(); src_wr = '{8'h11, 8'h22, 8'h33, 8'h44}; stall_wr_req = 1'b1;
    run_txn(1'b0, 1'b1, 24'h102030, 8'd4, 0);
    chk("wr_stall_used", stall_wr_req, 0);
    chk("wr_stall_data", {tx_log[5], tx_log[6], tx_log[7], tx_log[8]}, 32'h11223344);

    // Read with rd_ready held low 5 cycles on the first byte.
    model_clear(); src_rd = '{8'h81, 8'h42, 8'h24}; rd_stall = 5;
    run_txn(1'b1, 1'b0, 24'h777777, 8'd3, 0);
    chk("rd_stall_data", {rd_log[0], rd_log[1], rd_log[2]}, 24'h814224);

    // Zero-length quad read: header and dummy only.
    model_clear();
    run_txn(1'b1, 1'b1, 24'h000010, 8'd0, 0);
    chk("len0_tx_count", tx_log.size(), 5);

    // Reset while the address bytes are going out.
    model_clear(); src_rd = '{8'h01, 8'h02, 8'h03};
    run_txn(1'b1, 1'b0, 24'h456789, 8'd3, 2);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear(); done_cnt = 0;
    repeat (5) step();
    chk("rst_no_txn_done", done_cnt, 0);
    chk("rst_req_ready_after", req_ready, 1);
    chk("rst_no_start", tx_log.size(), 2);

    // Randomised requests.
    for (int k = 0; k < 25; k++) begin
      model_clear();
      rw = 1'($urandom_range(0, 1));
      q = 1'($urandom_range(0, 1));
      len = 8'($urandom_range(0, 6));
      for (int i = 0; i < int'(len); i++) begin
        if (rw) src_rd.push_back(8'($urandom));
        else src_wr.push_back(8'($urandom));
      end
      if (k % 5 == 3) rd_stall = 3;
      run_txn(rw, q, 24'($urandom), len, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
